// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the data-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEPTH_DEFAULT = 64;
  localparam int unsigned IDX_W         = $clog2(DEPTH_DEFAULT);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Identifies one of the two requesters.
  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port favoured on contention.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  req_id_t ptr;

  // Single requester wins outright; on contention the pointer decides.
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // After a grant, favour the port that was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance && (|gnt)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port data memory between the CPU LSU (port 0) and the
// display fetcher (port 1), with a built-in zero-fill engine.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [1:0]    req, gnt;
  logic          arb_adv;
  logic          in0, in1;
  logic [AW-1:0] a_q;
  logic [DW-1:0] wd_q;

  assign in0 = (m0_addr[AW-1:2] < (AW-2)'(DEPTH));
  assign in1 = (m1_addr[AW-1:2] < (AW-2)'(DEPTH));

  // Requests only compete while idle and out of reset.
  assign req     = ((state == IDLE) && !rst) ? {m1_req, m0_req} : 2'b00;
  assign arb_adv = (state == IDLE);
  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (arb_adv),
    .gnt     (gnt)
  );

  // Next state and memory-side drive; address/data hold when nobody owns the bus.
  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    mem_a    = a_q;
    mem_wd   = wd_q;
    clr_busy = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) state_nx = CLEAR;
        if (gnt[0]) begin
          mem_we = m0_we & in0;
          mem_a  = m0_addr;
          mem_wd = m0_wdata;
        end else if (gnt[1]) begin
          mem_we = m1_we & in1;
          mem_a  = m1_addr;
          mem_wd = m1_wdata;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        mem_we   = 1'b1;
        mem_a    = AW'({idx, 2'b00});
        mem_wd   = '0;
        if (idx == IW'(DEPTH - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, clear index, held bus values and the completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nx;
      a_q      <= mem_a;
      wd_q     <= mem_wd;
      clr_done <= (state == CLEAR) && (state_nx == IDLE);
      if ((state == CLEAR) && (state_nx == CLEAR)) begin
        idx <= idx + IW'(1);
      end else begin
        idx <= '0;
      end
    end
  end

  // Read responses: capture at the end of the grant cycle, pulse valid next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt[0] & ~m0_we;
      m1_rvalid <= gnt[1] & ~m1_we;
      if (gnt[0] && !m0_we) m0_rdata <= in0 ? mem_rd : '0;
      if (gnt[1] && !m1_we) m1_rdata <= in1 ? mem_rd : '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 64-word memory attached.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        clr_start, clr_busy, clr_done;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] stamp;
  } sb_t;

  sb_t         q0[$];
  sb_t         q1[$];
  sb_t         mon_e;
  logic [31:0] ref_mem [64];
  logic [31:0] env_mem [64];
  bit          mem_init;
  logic [31:0] cyc;
  int          n_vec = 0;
  int          n_err = 0;
  int          we_cnt = 0;
  int          done_cnt = 0;
  bit          rr_model;
  int          w;
  int          w0;
  int          d0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h0000_00AB : ((32'h0101_0101 * 32'(i)) ^ 32'h5A);
  endfunction

  // Attached memory: combinational read, out-of-range reads return junk.
  assign mem_rd = (mem_a[31:2] < 30'd64) ? env_mem[mem_a[7:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= init_word(i);
    end else if (mem_we && (mem_a[31:2] < 30'd64)) begin
      env_mem[mem_a[7:2]] <= mem_wd;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit p, input logic [31:0] data);
    sb_t e;
    e.data  = data;
    e.stamp = cyc + 32'd1;
    if (p) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  // Response monitor: every rvalid must match the oldest pending read, on time.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_rvalid) begin
        if (q0.size() == 0) check("rv0_spurious", 32'd1, 32'd0);
        else begin
          mon_e = q0.pop_front();
          check("rv0_time", cyc, mon_e.stamp);
          check("rd0", m0_rdata, mon_e.data);
        end
      end
      if (m1_rvalid) begin
        if (q1.size() == 0) check("rv1_spurious", 32'd1, 32'd0);
        else begin
          mon_e = q1.pop_front();
          check("rv1_time", cyc, mon_e.stamp);
          check("rd1", m1_rdata, mon_e.data);
        end
      end
      if (mem_we)   we_cnt++;
      if (clr_done) done_cnt++;
    end
  end

  // One access on port p with only p requesting; returns cycles spent waiting.
  task automatic do_access(input bit p, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int waited);
    bit inr;
    bit got;
    inr    = (addr[31:2] < 30'd64);
    got    = 1'b0;
    waited = 0;
    if (p) begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    else   begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    while (!got && waited < 200) begin
      @(negedge clk);
      if (p ? m1_gnt : m0_gnt) got = 1'b1;
      else waited++;
    end
    check("gnt_seen", {31'b0, got}, 32'd1);
    if (got) begin
      check("gnt_other", {31'b0, (p ? m0_gnt : m1_gnt)}, 32'd0);
      check("mem_we",    {31'b0, mem_we}, {31'b0, (we && inr)});
      check("mem_a",     mem_a, addr);
      check("mem_wd",    mem_wd, wdata);
      if (!we)     push_exp(p, inr ? ref_mem[addr[7:2]] : 32'd0);
      else if (inr) ref_mem[addr[7:2]] = wdata;
      rr_model = ~p;
    end
    tick();
    if (p) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  // Full clear sequence, optionally with port 0 holding a read across it.
  task automatic run_clear(input bit hold);
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    if (hold) begin m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8; m0_wdata = 32'd0; end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("clr_busy", {31'b0, clr_busy}, 32'd1);
      check("clr_a",    mem_a, 32'(i) << 2);
      check("clr_we",   {31'b0, mem_we}, 32'd1);
      check("clr_wd",   mem_wd, 32'd0);
      check("clr_gnt0", {31'b0, m0_gnt}, 32'd0);
      check("clr_done_early", {31'b0, clr_done}, 32'd0);
      clr_start = (i == 10);
      tick();
      clr_start = 1'b0;
    end
    @(negedge clk);
    check("clr_done", {31'b0, clr_done}, 32'd1);
    check("clr_busy_end", {31'b0, clr_busy}, 32'd0);
    if (hold) begin
      check("gnt_after_clr", {31'b0, m0_gnt}, 32'd1);
      push_exp(1'b0, 32'd0);
      rr_model = 1'b1;
    end
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    check("clr_done_pulse", {31'b0, clr_done}, 32'd0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; mem_init = 1'b1; clr_start = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    rr_model = 1'b0;
    repeat (2) @(posedge clk);
    mem_init = 1'b0;
    #1;
    // Reset holds every output low even with a request pending.
    check("rst_gnt0",  {31'b0, m0_gnt}, 32'd0);
    check("rst_gnt1",  {31'b0, m1_gnt}, 32'd0);
    check("rst_rv0",   {31'b0, m0_rvalid}, 32'd0);
    check("rst_rd0",   m0_rdata, 32'd0);
    check("rst_busy",  {31'b0, clr_busy}, 32'd0);
    check("rst_we",    {31'b0, mem_we}, 32'd0);
    check("rst_a",     mem_a, 32'd0);
    check("rst_wd",    mem_wd, 32'd0);
    m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single read of word 2, granted in the request cycle; address then holds.
    do_access(1'b0, 1'b0, 32'h8, 32'd0, w);
    check("sr_wait", 32'(w), 32'd0);
    @(negedge clk);
    check("hold_a", mem_a, 32'h8);
    check("hold_we", {31'b0, mem_we}, 32'd0);
    tick();

    // Write via port 1, then contention, then read back via port 0.
    w0 = we_cnt;
    do_access(1'b1, 1'b1, 32'h3C, 32'hDEAD_BEEF, w);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h14;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cont_g0", {31'b0, m0_gnt}, {31'b0, (rr_model == 1'b0)});
      check("cont_g1", {31'b0, m1_gnt}, {31'b0, (rr_model == 1'b1)});
      push_exp(rr_model, ref_mem[rr_model ? 5 : 4]);
      rr_model = ~rr_model;
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    do_access(1'b0, 1'b0, 32'h3C, 32'd0, w);
    tick();
    check("wr_pulses", 32'(we_cnt - w0), 32'd1);

    // Read data holds across a later write on the same port.
    do_access(1'b0, 1'b1, 32'h20, 32'h1234_5678, w);
    check("rd_hold", m0_rdata, 32'hDEAD_BEEF);

    // Out-of-range write is granted but suppressed; read returns zero.
    do_access(1'b0, 1'b1, 32'h100, 32'h1111_1111, w);
    do_access(1'b0, 1'b0, 32'h100, 32'd0, w);
    tick();

    // Clear with a held request, then read everything back.
    run_clear(1'b1);
    for (int i = 0; i < 64; i++) do_access(1'b0, 1'b0, 32'(i) << 2, 32'd0, w);

    // Refill part of memory, then reset in the middle of a clear.
    for (int i = 0; i < 32; i++) do_access(1'b1, 1'b1, 32'(i) << 2, 32'hC0DE_0000 | 32'(i), w);
    do_access(1'b0, 1'b0, 32'h7C, 32'd0, w);
    tick(); tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (20) tick();
    check("mc_a_pre", mem_a, 32'd80);
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    check("mc_busy", {31'b0, clr_busy}, 32'd0);
    check("mc_we",   {31'b0, mem_we}, 32'd0);
    check("mc_a",    mem_a, 32'd0);
    check("mc_wd",   mem_wd, 32'd0);
    check("mc_rd0",  m0_rdata, 32'd0);
    check("mc_rd1",  m1_rdata, 32'd0);
    check("mc_done", {31'b0, clr_done}, 32'd0);
    for (int i = 0; i < 20; i++) ref_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rr_model = 1'b0;
    repeat (4) tick();
    check("mc_no_done", 32'(done_cnt - d0), 32'd0);
    check("mc_idle",    {31'b0, clr_busy}, 32'd0);
    for (int i = 0; i < 32; i++) do_access(1'b0, 1'b0, 32'(i) << 2, 32'd0, w);

    // A fresh clear restarts from index 0 and completes.
    run_clear(1'b0);
    for (int i = 16; i < 40; i++) do_access(1'b1, 1'b0, 32'(i) << 2, 32'd0, w);

    repeat (3) tick();
    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
